uart_tx: RTL and testbench

Serial transmitter for the CPU's console port, sitting directly downstream of the clock divider: it consumes the divider's per-bit-period strobe as `i_tick` and shifts parallel bytes out on a single TX line. Frames are LSB-first asynchronous serial with one start bit, configurable data width, optional parity and one or two stop bits. A valid/ready handshake lets the CPU I/O logic hand over one word at a time.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Word handoff between the CPU I/O logic and the console transmitter.
// The producer drives valid/data and the transmitter returns ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_ready;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready
    );
endinterface

// File: rtl/uart_tx.sv
// Console UART transmitter: LSB-first framing with optional parity,
// paced by the divider's per-bit strobe.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_tick,
    uart_tx_if.slave bus,
    output logic     o_tx,
    output logic     o_busy
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAR   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]           state;
    logic [DATA_BITS-1:0] data_q;
    logic [IW-1:0]        bit_idx;
    logic                 stop_cnt;
    logic                 ready_q;
    logic                 par_bit;

    assign bus.o_ready = ready_q;

    // Odd parity inverts the even (plain XOR) result.
    assign par_bit = (PARITY == 1) ? ~(^data_q) : ^data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            data_q   <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            ready_q  <= 1'b1;
            o_busy   <= 1'b0;
            o_tx     <= 1'b1;
        end else if (state == S_IDLE) begin
            o_tx <= 1'b1;
            if (bus.i_valid && ready_q) begin
                data_q  <= bus.i_data;
                state   <= S_ARMED;
                ready_q <= 1'b0;
                o_busy  <= 1'b1;
            end
        end else if (i_tick) begin
            case (state)
                S_ARMED: begin
                    o_tx  <= 1'b0;
                    state <= S_START;
                end
                S_START: begin
                    o_tx    <= data_q[0];
                    bit_idx <= '0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (bit_idx < LAST_IDX) begin
                        bit_idx <= bit_idx + 1'b1;
                        o_tx    <= data_q[bit_idx + 1'b1];
                    end else if (PARITY != 0) begin
                        o_tx  <= par_bit;
                        state <= S_PAR;
                    end else begin
                        o_tx     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end
                end
                S_PAR: begin
                    o_tx     <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    o_tx <= 1'b1;
                    if (stop_cnt < STOP_LAST) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    o_busy  <= 1'b0;
                    o_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E1, 8O1 and 8N2 instances on a
// shared clock, reset and bit strobe.
module tb_uart_tx;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_tick;
    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] ready_w;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   tick_per = 16;
    int   tcnt     = 0;
    logic consumed = 1'b0;

    uart_tx_if #(.DATA_BITS(8)) u_if0 ();
    uart_tx_if #(.DATA_BITS(8)) u_if1 ();
    uart_tx_if #(.DATA_BITS(8)) u_if2 ();
    uart_tx_if #(.DATA_BITS(8)) u_if3 ();

    assign u_if0.i_valid = valid_r[0];
    assign u_if1.i_valid = valid_r[1];
    assign u_if2.i_valid = valid_r[2];
    assign u_if3.i_valid = valid_r[3];
    assign u_if0.i_data  = data_r[0];
    assign u_if1.i_data  = data_r[1];
    assign u_if2.i_data  = data_r[2];
    assign u_if3.i_data  = data_r[3];
    assign ready_w[0]    = u_if0.o_ready;
    assign ready_w[1]    = u_if1.o_ready;
    assign ready_w[2]    = u_if2.o_ready;
    assign ready_w[3]    = u_if3.o_ready;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
        .bus(u_if0), .o_tx(tx_w[0]), .o_busy(busy_w[0])
    );
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
        .bus(u_if1), .o_tx(tx_w[1]), .o_busy(busy_w[1])
    );
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
        .bus(u_if2), .o_tx(tx_w[2]), .o_busy(busy_w[2])
    );
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
        .bus(u_if3), .o_tx(tx_w[3]), .o_busy(busy_w[3])
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the strobe is re-driven 1ns after each edge.
    task automatic cyc();
        consumed = i_tick;
        @(posedge i_clk);
        #1;
        if (tick_per <= 1) begin
            i_tick = (tick_per == 1);
        end else begin
            tcnt   = (tcnt + 1) % tick_per;
            i_tick = (tcnt == 0);
        end
    endtask

    task automatic send(input int d, input logic [7:0] v);
        valid_r[d] = 1'b1;
        data_r[d]  = v;
        cyc();
        valid_r[d] = 1'b0;
    endtask

    // Collects n symbols, one per consumed tick; bits[s] is symbol s.
    task automatic frame(input int d, input int n, input logic init,
                         input bit fin, output logic [15:0] bits,
                         output int bad, output logic busy_before,
                         output logic ready_after);
        logic last;
        last        = init;
        bits        = '0;
        bad         = 0;
        busy_before = 1'b0;
        ready_after = 1'b0;
        for (int s = 0; s < n + (fin ? 1 : 0); s++) begin
            int w;
            w = 0;
            do begin
                cyc();
                w++;
                if (!consumed && tx_w[d] !== last) bad++;
            end while (!consumed && w < 100);
            if (!consumed) bad += 1000;
            if (s < n) begin
                bits[s]     = tx_w[d];
                last        = tx_w[d];
                busy_before = busy_w[d] & ~ready_w[d];
            end else begin
                ready_after = ready_w[d] & ~busy_w[d];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] b1;
        logic [15:0] b2;
        int          bad1;
        int          bad2;
        logic        bb;
        logic        ra;
        int          bad;
        int          w;

        i_rst   = 1'b1;
        i_tick  = 1'b0;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
        repeat (3) cyc();
        chk("rst_tx", tx_w, 4'hF);
        chk("rst_ready", ready_w, 4'hF);
        chk("rst_busy", busy_w, 4'h0);

        i_rst = 1'b0;
        bad   = 0;
        repeat (200) begin
            cyc();
            if (tx_w !== 4'hF || ready_w !== 4'hF || busy_w !== 4'h0) bad++;
        end
        chk("idle_hold", bad, 0);

        send(0, 8'hA5);
        chk("acc_ready", ready_w[0], 1'b0);
        chk("acc_busy", busy_w[0], 1'b1);
        frame(0, 10, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("n1_a5_bits", b1, 16'h034A);
        chk("n1_a5_hold", bad, 0);
        chk("n1_a5_busy", bb, 1'b1);
        chk("n1_a5_end", ra, 1'b1);

        send(1, 8'hA5);
        frame(1, 11, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("e1_a5_bits", b1, 16'h054A);
        chk("e1_a5_hold", bad, 0);
        chk("e1_a5_end", ra, 1'b1);

        send(2, 8'hA5);
        frame(2, 11, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("o1_a5_bits", b1, 16'h074A);
        chk("o1_a5_end", ra, 1'b1);

        send(1, 8'h07);
        frame(1, 11, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("e1_07_bits", b1, 16'h060E);
        chk("e1_07_end", ra, 1'b1);

        valid_r[3] = 1'b1;
        data_r[3]  = 8'h3C;
        cyc();
        chk("b2b_acc1", ready_w[3], 1'b0);
        data_r[3] = 8'h00;
        frame(3, 5, 1'b1, 1'b0, b1, bad1, bb, ra);
        data_r[3] = 8'hFF;
        frame(3, 6, b1[4], 1'b1, b2, bad2, bb, ra);
        chk("n2_3c_bits", b1 | (b2 << 5), 16'h0678);
        chk("n2_3c_hold", bad1 + bad2, 0);
        chk("n2_3c_busy", bb, 1'b1);
        chk("n2_3c_end", ra, 1'b1);
        cyc();
        chk("b2b_acc2", ready_w[3], 1'b0);
        valid_r[3] = 1'b0;
        frame(3, 11, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("n2_ff_bits", b1, 16'h07FE);
        chk("n2_ff_hold", bad, 0);
        chk("n2_ff_end", ra, 1'b1);

        w = 0;
        while (i_tick !== 1'b1 && w < 100) begin
            cyc();
            w++;
        end
        send(0, 8'h55);
        chk("tacc_tx", tx_w[0], 1'b1);
        chk("tacc_busy", busy_w[0], 1'b1);
        frame(0, 10, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("tacc_bits", b1, 16'h02AA);
        chk("tacc_hold", bad, 0);

        send(0, 8'h81);
        frame(0, 5, 1'b1, 1'b0, b1, bad, bb, ra);
        chk("r81_head", b1, 16'h0002);
        i_rst      = 1'b1;
        valid_r[0] = 1'b1;
        cyc();
        chk("mrst_tx", tx_w[0], 1'b1);
        chk("mrst_ready", ready_w[0], 1'b1);
        chk("mrst_busy", busy_w[0], 1'b0);
        i_rst = 1'b0;
        cyc();
        valid_r[0] = 1'b0;
        chk("r81_acc", ready_w[0], 1'b0);
        frame(0, 10, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("r81_bits", b1, 16'h0302);
        chk("r81_end", ra, 1'b1);

        tick_per = 1;
        tcnt     = 0;
        cyc();
        send(0, 8'hA5);
        frame(0, 10, 1'b1, 1'b1, b1, bad, bb, ra);
        chk("cont_bits", b1, 16'h034A);
        chk("cont_end", ra, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
